// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: definitions shared by the sequential ALU and its iterative
// multiply/divide unit.
//   - opcode encodings OP_ADD..OP_SLT
//   - iterative-unit mode encodings (multiply / divide)
//   - FSM state encoding for the top-level controller
//   - helper that tells which opcodes run on the iterative unit
package seq_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // MUL and DIV take N iterations; everything else completes in one cycle.
    function automatic logic is_iter_op(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: radix-2 iterative unsigned multiplier / restoring divider.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        load operands and begin N iterations (ignored values otherwise)
//   mode         MODE_MUL or MODE_DIV
//   A, B         operands (multiplier/multiplicand or dividend/divisor)
//   done         high in the cycle whose edge performs the final iteration
//   lo, hi       result after the current iteration (product low/high or
//                quotient/remainder); valid to register when done is high
//   dz           divide-by-zero flag for the operation in progress
// The hi/lo pair is shared: partial product for MUL, partial remainder and
// quotient-being-built for DIV.
module alu_muldiv_iter
    import seq_alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         mode,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         done,
    output logic [N-1:0] lo,
    output logic [N-1:0] hi,
    output logic         dz
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] cnt_r;
    logic          mode_r;
    logic          dz_r;
    logic [N-1:0]  opd_r;
    logic [N-1:0]  hi_r;
    logic [N-1:0]  lo_r;

    logic [N:0]    sum_s;
    logic [N:0]    shl_s;
    logic [N-1:0]  trial_s;
    logic          ge_s;
    logic [N-1:0]  hi_nxt_s;
    logic [N-1:0]  lo_nxt_s;

    // One iteration: shift-add for MUL, restoring subtract for DIV.
    always_comb begin
        sum_s    = {1'b0, hi_r} + ({(N+1){lo_r[0]}} & {1'b0, opd_r});
        shl_s    = {hi_r, lo_r[N-1]};
        // When the subtract succeeds the true difference is below the divisor,
        // so the low N bits of the shifted remainder are enough.
        trial_s  = shl_s[N-1:0] - opd_r;
        ge_s     = (shl_s >= {1'b0, opd_r});
        hi_nxt_s = hi_r;
        lo_nxt_s = lo_r;
        if (mode_r == MODE_DIV) begin
            if (ge_s) begin
                hi_nxt_s = trial_s;
            end else begin
                hi_nxt_s = shl_s[N-1:0];
            end
            lo_nxt_s = {lo_r[N-2:0], ge_s};
        end else begin
            hi_nxt_s = sum_s[N:1];
            lo_nxt_s = {sum_s[0], lo_r[N-1:1]};
        end
    end

    assign done = (cnt_r == {{(CW-1){1'b0}}, 1'b1});
    assign lo   = lo_nxt_s;
    assign hi   = hi_nxt_s;
    assign dz   = dz_r;

    // Operand load on start, then one iteration per cycle while the counter runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {CW{1'b0}};
            mode_r <= MODE_MUL;
            dz_r   <= 1'b0;
            opd_r  <= {N{1'b0}};
            hi_r   <= {N{1'b0}};
            lo_r   <= {N{1'b0}};
        end else if (start) begin
            cnt_r  <= CW'(N);
            mode_r <= mode;
            dz_r   <= (mode == MODE_DIV) && (B == {N{1'b0}});
            opd_r  <= B;
            hi_r   <= {N{1'b0}};
            lo_r   <= A;
        end else if (cnt_r != {CW{1'b0}}) begin
            cnt_r  <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
            hi_r   <= hi_nxt_s;
            lo_r   <= lo_nxt_s;
        end else begin
            cnt_r  <= cnt_r;
            hi_r   <= hi_r;
            lo_r   <= lo_r;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle handshaked unsigned ALU with a secondary result word.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   operand handshake (accept when both high at an edge)
//   A, B, OP             operands and opcode, captured on accept
//   out_valid, out_ready result handshake (transfer when both high at an edge)
//   C                    primary result
//   CH                   high product word (MUL), remainder (DIV), else 0
//   OV                   carry / borrow / product overflow / divide by zero
// Single-cycle ops finish at the accept edge; MUL/DIV run N iterations on
// alu_muldiv_iter. One operation is in flight at a time.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   OP,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] C,
    output logic [N-1:0] CH,
    output logic         OV
);

    state_t        state_r;
    state_t        next_state_s;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [N-1:0]  c_r;
    logic [N-1:0]  ch_r;
    logic          ov_r;
    logic [2:0]    op_r;

    logic [N:0]    sum_s;
    logic [N:0]    dif_s;
    logic [N-1:0]  sc_c_s;
    logic          sc_ov_s;

    logic          start_s;
    logic [N-1:0]  c_nxt_s;
    logic [N-1:0]  ch_nxt_s;
    logic          ov_nxt_s;
    logic [2:0]    op_nxt_s;

    logic          md_done_s;
    logic [N-1:0]  md_lo_s;
    logic [N-1:0]  md_hi_s;
    logic          md_dz_s;

    assign sum_s = {1'b0, A} + {1'b0, B};
    // Top bit of the widened difference is the borrow, i.e. A < B.
    assign dif_s = {1'b0, A} - {1'b0, B};

    // Single-cycle datapath, evaluated on the live operands at the accept edge.
    always_comb begin
        sc_c_s  = {N{1'b0}};
        sc_ov_s = 1'b0;
        case (OP)
            OP_ADD: begin
                sc_c_s  = sum_s[N-1:0];
                sc_ov_s = sum_s[N];
            end
            OP_SUB: begin
                sc_c_s  = dif_s[N-1:0];
                sc_ov_s = dif_s[N];
            end
            OP_AND:  sc_c_s = A & B;
            OP_OR:   sc_c_s = A | B;
            OP_XOR:  sc_c_s = A ^ B;
            OP_SLT:  sc_c_s = {{(N-1){1'b0}}, dif_s[N]};
            default: sc_c_s = {N{1'b0}};
        endcase
    end

    alu_muldiv_iter #(.N(N)) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_s),
        .mode  ((OP == OP_DIV) ? MODE_DIV : MODE_MUL),
        .A     (A),
        .B     (B),
        .done  (md_done_s),
        .lo    (md_lo_s),
        .hi    (md_hi_s),
        .dz    (md_dz_s)
    );

    // Controller: next state and next values of the result registers.
    always_comb begin
        next_state_s = state_r;
        start_s      = 1'b0;
        c_nxt_s      = c_r;
        ch_nxt_s     = ch_r;
        ov_nxt_s     = ov_r;
        op_nxt_s     = op_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    op_nxt_s = OP;
                    if (is_iter_op(OP)) begin
                        start_s      = 1'b1;
                        next_state_s = ST_BUSY;
                    end else begin
                        c_nxt_s      = sc_c_s;
                        ch_nxt_s     = {N{1'b0}};
                        ov_nxt_s     = sc_ov_s;
                        next_state_s = ST_DONE;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (md_done_s) begin
                    next_state_s = ST_DONE;
                    ch_nxt_s     = md_hi_s;
                    if (op_r == OP_DIV) begin
                        // Divide by zero: quotient saturates, remainder is A.
                        if (md_dz_s) begin
                            c_nxt_s  = {N{1'b1}};
                            ov_nxt_s = 1'b1;
                        end else begin
                            c_nxt_s  = md_lo_s;
                            ov_nxt_s = 1'b0;
                        end
                    end else begin
                        c_nxt_s  = md_lo_s;
                        ov_nxt_s = (md_hi_s != {N{1'b0}});
                    end
                end else begin
                    next_state_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State, handshake flags and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            c_r         <= {N{1'b0}};
            ch_r        <= {N{1'b0}};
            ov_r        <= 1'b0;
            op_r        <= OP_ADD;
        end else begin
            state_r     <= next_state_s;
            in_ready_r  <= (next_state_s == ST_IDLE);
            out_valid_r <= (next_state_s == ST_DONE);
            c_r         <= c_nxt_s;
            ch_r        <= ch_nxt_s;
            ov_r        <= ov_nxt_s;
            op_r        <= op_nxt_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign C         = c_r;
    assign CH        = ch_r;
    assign OV        = ov_r;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: table of vectors plus random ops with a
// scoreboard, then backpressure, mid-operation reset and back-to-back streams.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [2:0]   OP;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] C;
    logic [N-1:0] CH;
    logic         OV;

    seq_alu #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .OP        (OP),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (C),
        .CH        (CH),
        .OV        (OV)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2:0]   op;
        logic [N-1:0] c;
        logic [N-1:0] ch;
        logic         ov;
    } vec_t;

    typedef struct {
        logic [N-1:0] c;
        logic [N-1:0] ch;
        logic         ov;
        int           lat;
        int           acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[15];
    int   checks = 0;
    int   errors = 0;
    int   cycle_cnt = 0;
    int   acc_count = 0;
    int   rise_cyc = 0;
    logic vld_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model built from plain wide arithmetic.
    function automatic vec_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
        vec_t v;
        logic [2*N-1:0] p;
        logic [N:0] s;
        v.a = a; v.b = b; v.op = op; v.c = '0; v.ch = '0; v.ov = 1'b0;
        case (op)
            OP_ADD: begin s = {1'b0, a} + {1'b0, b}; v.c = s[N-1:0]; v.ov = s[N]; end
            OP_SUB: begin v.c = a - b; v.ov = (a < b); end
            OP_MUL: begin
                p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
                v.c = p[N-1:0]; v.ch = p[2*N-1:N]; v.ov = (v.ch != '0);
            end
            OP_DIV: begin
                if (b == '0) begin v.c = '1; v.ch = a; v.ov = 1'b1; end
                else begin v.c = a / b; v.ch = a % b; end
            end
            OP_AND: v.c = a & b;
            OP_OR:  v.c = a | b;
            OP_XOR: v.c = a ^ b;
            default: v.c = (a < b) ? 32'd1 : 32'd0;
        endcase
        return v;
    endfunction

    // Cycle counter and accept counter.
    always @(posedge clk) begin
        cycle_cnt <= cycle_cnt + 1;
        if (rst_n && in_valid && in_ready) acc_count <= acc_count + 1;
    end

    // Output monitor: latency from first out_valid, values at transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !vld_prev) rise_cyc = cycle_cnt;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", out_valid, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("C", C, mon_e.c);
                    check("CH", CH, mon_e.ch);
                    check("OV", OV, mon_e.ov);
                    check("latency", rise_cyc - mon_e.acc_cyc + 1, mon_e.lat);
                end
            end
        end
        vld_prev = out_valid;
    end

    // Waits for in_ready, presents one operation and pushes its expectation.
    task automatic issue(input vec_t v);
        exp_t e;
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", in_ready, 1);
        end else begin
            A = v.a; B = v.b; OP = v.op; in_valid = 1'b1;
            e.c = v.c; e.ch = v.ch; e.ov = v.ov;
            e.lat = is_iter_op(v.op) ? N + 1 : 1;
            e.acc_cyc = cycle_cnt + 1;
            sb_q.push_back(e);
            @(posedge clk); #1;
            in_valid = 1'b0;
            A = $urandom; B = $urandom; OP = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((sb_q.size() != 0 || out_valid) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) check("drain_timeout", sb_q.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_C"}, C, 0);
        check({tag, "_CH"}, CH, 0);
        check({tag, "_OV"}, OV, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int t0, t1, t2, acc_before, seen;
        vec_t bp;

        vecs[0]  = '{32'd345, 32'd234, OP_ADD, 32'd579, 32'd0, 1'b0};
        vecs[1]  = '{32'd213, 32'd345, OP_SUB, 32'hFFFF_FF7C, 32'd0, 1'b1};
        vecs[2]  = '{32'hFFFF_FFFF, 32'd2, OP_ADD, 32'd1, 32'd0, 1'b1};
        vecs[3]  = '{32'd437, 32'd768, OP_MUL, 32'd335616, 32'd0, 1'b0};
        vecs[4]  = '{32'h0001_0000, 32'h0001_0000, OP_MUL, 32'd0, 32'd1, 1'b1};
        vecs[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MUL, 32'd1, 32'hFFFF_FFFE, 1'b1};
        vecs[6]  = '{32'd922, 32'd346, OP_DIV, 32'd2, 32'd230, 1'b0};
        vecs[7]  = '{32'd962, 32'd0, OP_DIV, 32'hFFFF_FFFF, 32'd962, 1'b1};
        vecs[8]  = '{32'd5, 32'd7, OP_DIV, 32'd0, 32'd5, 1'b0};
        vecs[9]  = '{32'hFFFF_FFFF, 32'd1, OP_DIV, 32'hFFFF_FFFF, 32'd0, 1'b0};
        vecs[10] = '{32'd5, 32'd3, OP_OR, 32'd7, 32'd0, 1'b0};
        vecs[11] = '{32'd5, 32'd3, OP_XOR, 32'd6, 32'd0, 1'b0};
        vecs[12] = '{32'd215, 32'd267, OP_SLT, 32'd1, 32'd0, 1'b0};
        vecs[13] = '{32'd267, 32'd215, OP_SLT, 32'd0, 32'd0, 1'b0};
        vecs[14] = '{32'd5, 32'd5, OP_SUB, 32'd0, 32'd0, 1'b0};

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; OP = OP_ADD;
        #2 rst_n = 1'b0;
        #10 check_reset_values("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) issue(vecs[i]);
        for (int i = 0; i < 10; i++) begin
            issue(model($urandom, (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom,
                        3'($urandom_range(0, 7))));
        end
        wait_drain();

        // Backpressure on a single-cycle AND.
        out_ready = 1'b0;
        bp = model(32'd67, 32'd24, OP_AND);
        issue(bp);
        acc_before = acc_count;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_C_stable", C, bp.c);
            check("bp_in_ready", in_ready, 0);
            if (i == 2) begin A = 32'd9; B = 32'd9; OP = OP_ADD; in_valid = 1'b1; end
            else in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bp_no_accept", acc_count, acc_before);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_in_ready_after", in_ready, 1);
        check("bp_out_valid_after", out_valid, 0);
        check("bp_queue_empty", sb_q.size(), 0);

        // Reset in the middle of a multiply.
        issue(model(32'd215, 32'd267, OP_MUL));
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midreset");
        sb_q.delete();
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        check("no_output_after_reset", seen, 0);
        issue(model(32'd215, 32'd267, OP_SLT));
        wait_drain();

        // Back-to-back single-cycle stream.
        issue(model(32'd10, 32'd20, OP_ADD)); t0 = cycle_cnt;
        issue(model(32'd5, 32'd3, OP_XOR));   t1 = cycle_cnt;
        issue(model(32'd5, 32'd3, OP_OR));    t2 = cycle_cnt;
        check("b2b_spacing_1", t1 - t0, 2);
        check("b2b_spacing_2", t2 - t1, 2);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
